// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler.
//   tx_state_e      : scheduler FSM state encoding (IDLE / WRITE / BUSY)
//   BAUD_DEFAULT    : baud code driven out of reset
//   DATA_W_DEFAULT  : default byte width, matches the transmitter's Tx_DATA
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_BUSY  = 2'd2
  } tx_state_e;

  localparam logic [2:0] BAUD_DEFAULT   = 3'b111;
  localparam int         DATA_W_DEFAULT = 8;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first asserted request strictly after ptr, wrapping modulo NUM_REQ.
// The pointer register itself lives in the parent.
//   req         in   NUM_REQ          request vector
//   ptr         in   clog2(NUM_REQ)   last served requester
//   grant       out  NUM_REQ          one-hot winner (all zero when no request)
//   grant_idx   out  clog2(NUM_REQ)   winner index
//   grant_valid out  1                at least one request present
module uart_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       grant_valid
);

  localparam int IW = $clog2(NUM_REQ);

  always_comb begin
    logic [IW-1:0] cand;
    cand        = '0;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    // Walk offsets from farthest to nearest so the nearest requester after
    // the pointer is the last one written and therefore wins.
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = IW'((int'(ptr) + off) % NUM_REQ);
      if (req[cand]) begin
        grant_idx   = cand;
        grant_valid = 1'b1;
      end
    end
    if (grant_valid) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between NUM_REQ byte sources (round-robin),
// drives the Tx_EN/Tx_WR/Tx_DATA handshake, tracks Tx_BUSY and owns the
// baud_select register, which only changes between frames.
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-low
//   req          in   per-requester level request
//   req_data     in   requester i byte at [i*DATA_W +: DATA_W]
//   ack          out  one-cycle pulse when the transmitter accepted a byte
//   cfg_wr       in   pulse: load baud_cfg
//   baud_cfg     in   new baud code
//   Tx_BUSY      in   transmitter busy
//   Tx_EN        out  transmitter enable
//   Tx_WR        out  write strobe
//   Tx_DATA      out  byte to transmitter
//   baud_select  out  baud code to transmitter and receiver
//   grant_id     out  current/last granted requester
//   err_timeout  out  sticky: a write was aborted
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int WR_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         ack,
  input  logic                       cfg_wr,
  input  logic [2:0]                 baud_cfg,
  input  logic                       Tx_BUSY,
  output logic                       Tx_EN,
  output logic                       Tx_WR,
  output logic [DATA_W-1:0]          Tx_DATA,
  output logic [2:0]                 baud_select,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       err_timeout
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(WR_TIMEOUT + 1);

  // Unpack the flat data bus into one byte per requester.
  logic [DATA_W-1:0] req_bytes [NUM_REQ];
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_bytes[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  tx_state_e         state_q, state_d;
  logic              tx_en_q, tx_en_d;
  logic              tx_wr_q, tx_wr_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REQ-1:0] grant_oh_q, grant_oh_d;
  logic [IW-1:0]     grant_id_q, grant_id_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic              err_q, err_d;
  logic [2:0]        baud_q, baud_d;
  logic              cfg_pend_q, cfg_pend_d;
  logic [2:0]        cfg_val_q, cfg_val_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IW-1:0]      arb_idx;
  logic               arb_valid;

  uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req         (req),
    .ptr         (ptr_q),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  always_comb begin
    state_d    = state_q;
    tx_en_d    = 1'b1;
    tx_wr_d    = tx_wr_q;
    tx_data_d  = tx_data_q;
    ack_d      = '0;
    grant_oh_d = grant_oh_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    err_d      = err_q;
    baud_d     = baud_q;
    cfg_pend_d = cfg_pend_q;
    cfg_val_d  = cfg_val_q;
    cnt_d      = cnt_q;

    // Mid-frame config writes are parked; the last one wins.
    if (cfg_wr && (state_q != ST_IDLE)) begin
      cfg_pend_d = 1'b1;
      cfg_val_d  = baud_cfg;
    end

    case (state_q)
      ST_IDLE: begin
        // Config always takes the IDLE cycle ahead of any grant, so the baud
        // code is settled before the next byte starts.
        if (cfg_pend_q || cfg_wr) begin
          baud_d     = cfg_wr ? baud_cfg : cfg_val_q;
          cfg_pend_d = 1'b0;
          err_d      = 1'b0;
        end else if (!Tx_BUSY && arb_valid) begin
          tx_data_d  = req_bytes[arb_idx];
          grant_id_d = arb_idx;
          grant_oh_d = arb_grant;
          tx_wr_d    = 1'b1;
          cnt_d      = '0;
          state_d    = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (Tx_BUSY) begin
          tx_wr_d = 1'b0;
          ack_d   = grant_oh_q;
          ptr_d   = grant_id_q;
          state_d = ST_BUSY;
        end else if (cnt_q == CW'(WR_TIMEOUT - 1)) begin
          // Abort; still advance the pointer so a dead requester cannot
          // monopolise the transmitter.
          tx_wr_d = 1'b0;
          err_d   = 1'b1;
          ptr_d   = grant_id_q;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_BUSY: begin
        if (!Tx_BUSY) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      tx_en_q    <= 1'b0;
      tx_wr_q    <= 1'b0;
      tx_data_q  <= '0;
      ack_q      <= '0;
      grant_oh_q <= '0;
      grant_id_q <= '0;
      ptr_q      <= IW'(NUM_REQ - 1);
      err_q      <= 1'b0;
      baud_q     <= BAUD_DEFAULT;
      cfg_pend_q <= 1'b0;
      cfg_val_q  <= BAUD_DEFAULT;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      tx_en_q    <= tx_en_d;
      tx_wr_q    <= tx_wr_d;
      tx_data_q  <= tx_data_d;
      ack_q      <= ack_d;
      grant_oh_q <= grant_oh_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
      err_q      <= err_d;
      baud_q     <= baud_d;
      cfg_pend_q <= cfg_pend_d;
      cfg_val_q  <= cfg_val_d;
      cnt_q      <= cnt_d;
    end
  end

  assign Tx_EN       = tx_en_q;
  assign Tx_WR       = tx_wr_q;
  assign Tx_DATA     = tx_data_q;
  assign ack         = ack_q;
  assign grant_id    = grant_id_q;
  assign baud_select = baud_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  ack;
  logic        cfg_wr = 1'b0;
  logic [2:0]  baud_cfg = '0;
  logic        Tx_BUSY = 1'b0;
  logic        Tx_EN;
  logic        Tx_WR;
  logic [7:0]  Tx_DATA;
  logic [2:0]  baud_select;
  logic [1:0]  grant_id;
  logic        err_timeout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx_scheduler #(.NUM_REQ(4), .DATA_W(8), .WR_TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .cfg_wr      (cfg_wr),
    .baud_cfg    (baud_cfg),
    .Tx_BUSY     (Tx_BUSY),
    .Tx_EN       (Tx_EN),
    .Tx_WR       (Tx_WR),
    .Tx_DATA     (Tx_DATA),
    .baud_select (baud_select),
    .grant_id    (grant_id),
    .err_timeout (err_timeout)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Waits (bounded) at negedges for Tx_WR to be high.
  task automatic wait_wr(output logic found);
    found = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (Tx_WR === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Plays the transmitter for one frame and reports what it saw.
  task automatic serve_frame(output logic found, output logic [1:0] id,
                             output logic [7:0] data, output logic [3:0] ack_first,
                             output logic [3:0] ack_other, output logic wr_after);
    id = '0; data = '0; ack_first = '0; ack_other = '0; wr_after = 1'b1;
    wait_wr(found);
    if (found) begin
      id = grant_id;
      data = Tx_DATA;
      ack_other = ack;
      Tx_BUSY = 1'b1;
      @(negedge clk);
      ack_first = ack;
      wr_after = Tx_WR;
      repeat (2) begin
        @(negedge clk);
        ack_other |= ack;
      end
      Tx_BUSY = 1'b0;
      @(negedge clk);
      ack_other |= ack;
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (Tx_EN !== 1'b0) begin errors++; $display("FAIL rst_tx_en: got %b want 0", Tx_EN); end
    checks++; if (Tx_WR !== 1'b0) begin errors++; $display("FAIL rst_tx_wr: got %b want 0", Tx_WR); end
    checks++; if (Tx_DATA !== 8'h00) begin errors++; $display("FAIL rst_tx_data: got %h want 00", Tx_DATA); end
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL rst_ack: got %b want 0000", ack); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_grant_id: got %0d want 0", grant_id); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err_timeout); end
    checks++; if (baud_select !== 3'b111) begin errors++; $display("FAIL rst_baud: got %b want 111", baud_select); end
  endtask

  task automatic test_single();
    req = 4'b0001;
    req_data[7:0] = 8'h94;
    reset = 1'b1;
    @(negedge clk);
    checks++; if (Tx_EN !== 1'b1) begin errors++; $display("FAIL single_tx_en: got %b want 1", Tx_EN); end
    checks++; if (Tx_WR !== 1'b1) begin errors++; $display("FAIL single_wr_latency: got %b want 1", Tx_WR); end
    checks++; if (Tx_DATA !== 8'h94) begin errors++; $display("FAIL single_data: got %h want 94", Tx_DATA); end
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL single_early_ack: got %b want 0000", ack); end
    Tx_BUSY = 1'b1;
    @(negedge clk);
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL single_ack: got %b want 0001", ack); end
    checks++; if (Tx_WR !== 1'b0) begin errors++; $display("FAIL single_wr_drop: got %b want 0", Tx_WR); end
    req = 4'b0000;
    @(negedge clk);
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL single_ack_pulse: got %b want 0000", ack); end
    Tx_BUSY = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic found, wr_after;
    logic [1:0] id;
    logic [7:0] data;
    logic [3:0] af, ao, exp_ack;
    logic [1:0] exp_id [5];
    logic [7:0] exp_data [4];
    exp_id[0] = 2'd0; exp_id[1] = 2'd1; exp_id[2] = 2'd2; exp_id[3] = 2'd3; exp_id[4] = 2'd0;
    exp_data[0] = 8'h10; exp_data[1] = 8'h21; exp_data[2] = 8'h32; exp_data[3] = 8'h43;
    req_data = 32'h43322110;
    req = 4'b1111;
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      serve_frame(found, id, data, af, ao, wr_after);
      exp_ack = 4'b0001 << exp_id[k];
      checks++; if (found !== 1'b1) begin errors++; $display("FAIL rr_found[%0d]: got %b want 1", k, found); end
      checks++; if (id !== exp_id[k]) begin errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, id, exp_id[k]); end
      checks++; if (data !== exp_data[exp_id[k]]) begin errors++; $display("FAIL rr_data[%0d]: got %h want %h", k, data, exp_data[exp_id[k]]); end
      checks++; if (af !== exp_ack) begin errors++; $display("FAIL rr_ack[%0d]: got %b want %b", k, af, exp_ack); end
      checks++; if (ao !== 4'b0000) begin errors++; $display("FAIL rr_extra_ack[%0d]: got %b want 0000", k, ao); end
      checks++; if (wr_after !== 1'b0) begin errors++; $display("FAIL rr_wr_drop[%0d]: got %b want 0", k, wr_after); end
    end
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_pointer();
    logic found, wr_after;
    logic [1:0] id;
    logic [7:0] data;
    logic [3:0] af, ao;
    req_data = 32'hA3A2A1A0;
    req = 4'b0001;
    apply_reset();
    serve_frame(found, id, data, af, ao, wr_after);
    req = 4'b0010;
    serve_frame(found, id, data, af, ao, wr_after);
    checks++; if (id !== 2'd1) begin errors++; $display("FAIL ptr_setup: got %0d want 1", id); end
    req = 4'b1001;
    serve_frame(found, id, data, af, ao, wr_after);
    checks++; if (id !== 2'd3) begin errors++; $display("FAIL ptr_first: got %0d want 3", id); end
    checks++; if (data !== 8'hA3) begin errors++; $display("FAIL ptr_first_data: got %h want A3", data); end
    req = 4'b0011;
    serve_frame(found, id, data, af, ao, wr_after);
    checks++; if (id !== 2'd0) begin errors++; $display("FAIL ptr_wrap: got %0d want 0", id); end
    checks++; if (af !== 4'b0001) begin errors++; $display("FAIL ptr_wrap_ack: got %b want 0001", af); end
    req = 4'b0010;
    serve_frame(found, id, data, af, ao, wr_after);
    checks++; if (id !== 2'd1) begin errors++; $display("FAIL ptr_late: got %0d want 1", id); end
    checks++; if (data !== 8'hA1) begin errors++; $display("FAIL ptr_late_data: got %h want A1", data); end
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_cfg_busy();
    logic found, wr_after;
    logic [1:0] id;
    logic [7:0] data;
    logic [3:0] af, ao;
    req_data[23:16] = 8'h5A;
    req = 4'b0100;
    wait_wr(found);
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL cfg_wr_seen: got %b want 1", found); end
    Tx_BUSY = 1'b1;
    @(negedge clk);
    cfg_wr = 1'b1; baud_cfg = 3'b101;
    @(negedge clk);
    baud_cfg = 3'b010;
    @(negedge clk);
    cfg_wr = 1'b0;
    checks++; if (baud_select !== 3'b111) begin errors++; $display("FAIL cfg_hold_busy: got %b want 111", baud_select); end
    @(negedge clk);
    Tx_BUSY = 1'b0;
    @(negedge clk);
    checks++; if (baud_select !== 3'b111) begin errors++; $display("FAIL cfg_hold_idle: got %b want 111", baud_select); end
    @(negedge clk);
    checks++; if (baud_select !== 3'b010) begin errors++; $display("FAIL cfg_applied: got %b want 010", baud_select); end
    checks++; if (Tx_WR !== 1'b0) begin errors++; $display("FAIL cfg_no_grant: got %b want 0", Tx_WR); end
    @(negedge clk);
    checks++; if (Tx_WR !== 1'b1) begin errors++; $display("FAIL cfg_then_grant: got %b want 1", Tx_WR); end
    serve_frame(found, id, data, af, ao, wr_after);
    checks++; if (af !== 4'b0100) begin errors++; $display("FAIL cfg_frame_ack: got %b want 0100", af); end
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    logic found;
    int wr_cycles;
    logic [3:0] ack_seen;
    req_data[15:8] = 8'h77;
    req = 4'b0010;
    wait_wr(found);
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL to_wr_seen: got %b want 1", found); end
    wr_cycles = 0;
    ack_seen = '0;
    while (Tx_WR === 1'b1 && wr_cycles < 40) begin
      wr_cycles++;
      ack_seen |= ack;
      @(negedge clk);
    end
    ack_seen |= ack;
    req = 4'b0000;
    checks++; if (wr_cycles != 16) begin errors++; $display("FAIL to_wr_len: got %0d want 16", wr_cycles); end
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_err_set: got %b want 1", err_timeout); end
    checks++; if (ack_seen !== 4'b0000) begin errors++; $display("FAIL to_no_ack: got %b want 0000", ack_seen); end
    @(negedge clk);
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_err_sticky: got %b want 1", err_timeout); end
    cfg_wr = 1'b1; baud_cfg = 3'b011;
    @(negedge clk);
    cfg_wr = 1'b0;
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_err_clear: got %b want 0", err_timeout); end
    checks++; if (baud_select !== 3'b011) begin errors++; $display("FAIL to_baud: got %b want 011", baud_select); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    logic found, wr_after;
    logic [1:0] id;
    logic [7:0] data;
    logic [3:0] af, ao;
    req_data[23:16] = 8'hC3;
    req = 4'b0100;
    wait_wr(found);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (Tx_WR !== 1'b0) begin errors++; $display("FAIL mid_rst_wr: got %b want 0", Tx_WR); end
    checks++; if (Tx_EN !== 1'b0) begin errors++; $display("FAIL mid_rst_en: got %b want 0", Tx_EN); end
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL mid_rst_ack: got %b want 0000", ack); end
    checks++; if (baud_select !== 3'b111) begin errors++; $display("FAIL mid_rst_baud: got %b want 111", baud_select); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (Tx_EN !== 1'b1) begin errors++; $display("FAIL mid_rel_en: got %b want 1", Tx_EN); end
    checks++; if (Tx_WR !== 1'b1) begin errors++; $display("FAIL mid_rel_wr: got %b want 1", Tx_WR); end
    checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL mid_rel_id: got %0d want 2", grant_id); end
    checks++; if (Tx_DATA !== 8'hC3) begin errors++; $display("FAIL mid_rel_data: got %h want C3", Tx_DATA); end
    serve_frame(found, id, data, af, ao, wr_after);
    checks++; if (af !== 4'b0100) begin errors++; $display("FAIL mid_rel_ack: got %b want 0100", af); end
    req = 4'b0000;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_pointer();
    test_cfg_busy();
    test_timeout();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
